// File: rtl/uart_loader_pkg.sv
// Shared constants, state encodings and error-bit positions for the UART loader.
package uart_loader_pkg;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  // Positions inside the sticky err vector {overflow, timeout, framing}
  localparam int ERR_FRAMING  = 0;
  localparam int ERR_TIMEOUT  = 1;
  localparam int ERR_OVERFLOW = 2;

  typedef enum logic [2:0] {
    HUNT,
    LEN0,
    LEN1,
    PAYLOAD,
    WRITE,
    CHK,
    REPLY
  } FrameState;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } RxState;

endpackage

// File: rtl/uart_loader_if.sv
// Memory write port driven by the loader: word address, word data, one-cycle strobe.
interface uart_loader_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              write;

  modport master (output addr, data, write);
  modport slave  (input  addr, data, write);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronises rx, times the bits, checks the stop bit and
// pulses byteValid_o (or frameErr_o) on the cycle after the stop-bit sample.
module uart_byte_rx
  import uart_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rx_i,
  output logic       startDet_o,
  output logic       byteValid_o,
  output logic       frameErr_o,
  output logic [7:0] byteData_o
);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

  logic             rxMeta_q, rxSync_q, rxPrev_q;
  RxState           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byteValid_q, byteValid_d;
  logic             frameErr_q, frameErr_d;
  logic             fall;

  assign fall        = rxPrev_q & ~rxSync_q;
  assign startDet_o  = (state_q == RX_IDLE) && fall;
  assign byteValid_o = byteValid_q;
  assign frameErr_o  = frameErr_q;
  assign byteData_o  = shift_q;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // Receiver state and bit-timing registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // Start re-check at half a bit, data every bit period LSB first, then stop check
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rxSync_q) byteValid_d = 1'b1;
          else          frameErr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: receives framed program images over 8N1, writes each word to
// memory with a one-cycle strobe and answers every frame with ACK or NAK.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int ADDR_W        = 23,
  parameter int DATA_W        = 32,
  parameter int TIMEOUT_BYTES = 16
) (
  input  logic          clk_50mhz,
  input  logic          rstn,
  input  logic          enable,
  input  logic          rx,
  output logic          tx,
  uart_loader_if.master mem,
  output logic          busy,
  output logic [7:0]    xorc,
  output logic [2:0]    err
);
  localparam int DIV      = CLK_HZ / BAUD;
  localparam int BYTES    = DATA_W / 8;
  localparam int BIDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W    = $clog2(DIV);
  localparam int TO_LIMIT = TIMEOUT_BYTES * 10 * DIV;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic              rxStart, rxValid, rxErr;
  logic [7:0]        rxByte;
  FrameState         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       len_q, wordCnt_q;
  logic [BIDX_W-1:0] byteIdx_q;
  logic [7:0]        frameXor_q, xorc_q;
  logic [2:0]        err_q;
  logic              enablePrev_q;
  logic [TO_W-1:0]   toCnt_q;
  logic [9:0]        txShift_q;
  logic [CNT_W-1:0]  txCnt_q;
  logic [3:0]        txBitCnt_q;
  logic              txActive_q;
  logic              enableRise, inFrame, timeoutHit, lastByte, lastWord;
  logic              txDone, takePayload, loadReply, doWrite;

  uart_byte_rx #(.DIV(DIV)) u_rx (
    .clk_i       (clk_50mhz),
    .rstn_i      (rstn),
    .rx_i        (rx),
    .startDet_o  (rxStart),
    .byteValid_o (rxValid),
    .frameErr_o  (rxErr),
    .byteData_o  (rxByte)
  );

  assign enableRise = enable & ~enablePrev_q;
  assign inFrame    = (state_q != HUNT) && (state_q != REPLY);
  assign timeoutHit = inFrame && (toCnt_q == TO_W'(TO_LIMIT - 1));
  assign lastByte   = (byteIdx_q == BIDX_W'(BYTES - 1));
  assign lastWord   = (wordCnt_q == len_q - 16'd1);
  assign txDone     = txActive_q && (txCnt_q == CNT_W'(DIV - 1)) && (txBitCnt_q == 4'd9);
  assign doWrite    = (state_q == WRITE) && enable;

  assign mem.addr  = addr_q;
  assign mem.data  = data_q;
  assign mem.write = doWrite;
  assign tx        = txActive_q ? txShift_q[0] : 1'b1;
  assign busy      = (state_q != HUNT) || txActive_q;
  assign xorc      = xorc_q;
  assign err       = err_q;

  // Frame state register
  always_ff @(posedge clk_50mhz) begin
    if (!rstn) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // Frame sequencing; disarm, framing errors and timeouts all fall back to HUNT
  always_comb begin
    state_d     = state_q;
    takePayload = 1'b0;
    loadReply   = 1'b0;
    if (!enable) begin
      state_d = HUNT;
    end else if (rxErr && (state_q != REPLY)) begin
      state_d = HUNT;
    end else if (timeoutHit) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT:    if (rxValid && (rxByte == SYNC)) state_d = LEN0;
        LEN0:    if (rxValid) state_d = LEN1;
        LEN1:    if (rxValid) state_d = ({rxByte, len_q[7:0]} == 16'd0) ? CHK : PAYLOAD;
        PAYLOAD: begin
          if (rxValid) begin
            takePayload = 1'b1;
            if (lastByte) state_d = WRITE;
          end
        end
        WRITE:   state_d = lastWord ? CHK : PAYLOAD;
        CHK: begin
          if (rxValid) begin
            loadReply = 1'b1;
            state_d   = REPLY;
          end
        end
        REPLY:   if (txDone || !txActive_q) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Word assembly, address/length tracking, checksums and sticky errors
  always_ff @(posedge clk_50mhz) begin
    if (!rstn) begin
      addr_q       <= '0;
      data_q       <= '0;
      len_q        <= '0;
      wordCnt_q    <= '0;
      byteIdx_q    <= '0;
      frameXor_q   <= '0;
      xorc_q       <= '0;
      err_q        <= '0;
      enablePrev_q <= 1'b0;
    end else begin
      enablePrev_q <= enable;
      if (state_q == HUNT) begin
        frameXor_q <= '0;
        wordCnt_q  <= '0;
        byteIdx_q  <= '0;
      end
      if ((state_q == LEN0) && rxValid) len_q[7:0]  <= rxByte;
      if ((state_q == LEN1) && rxValid) len_q[15:8] <= rxByte;
      if (takePayload) begin
        data_q[8*int'(byteIdx_q) +: 8] <= rxByte;
        byteIdx_q  <= lastByte ? '0 : byteIdx_q + 1'b1;
        frameXor_q <= frameXor_q ^ rxByte;
        xorc_q     <= xorc_q ^ rxByte;
      end
      if (doWrite) begin
        wordCnt_q <= wordCnt_q + 16'd1;
        addr_q    <= addr_q + 1'b1;
        if (&addr_q) err_q[ERR_OVERFLOW] <= 1'b1;
      end
      if (rxErr && enable) err_q[ERR_FRAMING] <= 1'b1;
      if (timeoutHit && enable) err_q[ERR_TIMEOUT] <= 1'b1;
      if (enableRise) begin
        addr_q <= '0;
        xorc_q <= '0;
        err_q  <= '0;
      end
    end
  end

  // Idle counter that restarts on every byte start while a frame is open
  always_ff @(posedge clk_50mhz) begin
    if (!rstn)                    toCnt_q <= '0;
    else if (!inFrame || rxStart) toCnt_q <= '0;
    else                          toCnt_q <= toCnt_q + 1'b1;
  end

  // Reply shifter: start bit, 8 data bits LSB first, stop bit; runs to completion once loaded
  always_ff @(posedge clk_50mhz) begin
    if (!rstn) begin
      txShift_q  <= '1;
      txCnt_q    <= '0;
      txBitCnt_q <= '0;
      txActive_q <= 1'b0;
    end else if (loadReply) begin
      txShift_q  <= {1'b1, (rxByte == frameXor_q) ? ACK : NAK, 1'b0};
      txCnt_q    <= '0;
      txBitCnt_q <= '0;
      txActive_q <= 1'b1;
    end else if (txActive_q) begin
      if (txCnt_q == CNT_W'(DIV - 1)) begin
        txCnt_q   <= '0;
        txShift_q <= {1'b1, txShift_q[9:1]};
        if (txBitCnt_q == 4'd9) txActive_q <= 1'b0;
        else                    txBitCnt_q <= txBitCnt_q + 4'd1;
      end else begin
        txCnt_q <= txCnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Testbench for uart_loader: drives framed images on rx, queues the expected
// memory writes and replies, and compares them as the loader produces them.
module tb_uart_loader;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 100_000;
  localparam int DIV     = CLK_HZ / BAUD;
  // Narrow word address so the wrap is reachable with a short frame
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int TO_BYTES = 16;

  localparam logic [7:0] TB_SYNC = 8'hA5;
  localparam logic [7:0] TB_ACK  = 8'h06;
  localparam logic [7:0] TB_NAK  = 8'h15;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } WrExp;

  logic       clk = 1'b0;
  logic       rstn, enable, rx;
  logic       tx, busy;
  logic [7:0] xorc;
  logic [2:0] err;

  uart_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memBus ();

  uart_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_BYTES(TO_BYTES)
  ) dut (
    .clk_50mhz (clk),
    .rstn      (rstn),
    .enable    (enable),
    .rx        (rx),
    .tx        (tx),
    .mem       (memBus),
    .busy      (busy),
    .xorc      (xorc),
    .err       (err)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  WrExp              expWrites[$];
  logic [7:0]        expReplies[$];
  logic [31:0]       frameWords[$];
  logic [ADDR_W-1:0] expAddr = '0;
  logic [7:0]        expXorc = '0;
  logic [2:0]        expErr  = '0;
  logic              prevWrite = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One 8N1 byte on rx, with a selectable stop-bit level
  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (DIV) @(negedge clk);
    end
    rx = stopBit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  // Sends frameWords as one frame and queues the writes and reply it should produce
  task automatic applyStimulus(input bit forceChk, input logic [7:0] forcedChk);
    logic [7:0]  chk;
    logic [7:0]  sent;
    logic [15:0] len;
    WrExp        e;
    chk = 8'h00;
    len = 16'(frameWords.size());
    foreach (frameWords[i]) begin
      for (int k = 0; k < 4; k++) chk ^= frameWords[i][8*k +: 8];
      e.a = expAddr;
      e.d = frameWords[i];
      expWrites.push_back(e);
      if (expAddr == '1) expErr[2] = 1'b1;
      expAddr = expAddr + 1'b1;
    end
    sent = forceChk ? forcedChk : chk;
    expXorc ^= chk;
    expReplies.push_back((sent == chk) ? TB_ACK : TB_NAK);
    sendByte(TB_SYNC, 1'b1);
    sendByte(len[7:0], 1'b1);
    sendByte(len[15:8], 1'b1);
    foreach (frameWords[i]) begin
      for (int k = 0; k < 4; k++) sendByte(frameWords[i][8*k +: 8], 1'b1);
    end
    sendByte(sent, 1'b1);
  endtask

  task automatic waitIdle();
    int cycles;
    cycles = 0;
    while ((expWrites.size() != 0 || expReplies.size() != 0 || busy) && cycles < 6000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("drainTimeout", 32'(cycles >= 6000), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic rewindEnable();
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    expAddr = '0;
    expXorc = '0;
    expErr  = '0;
  endtask

  // Memory-side monitor: every strobe must match the oldest queued write and last one cycle
  always @(negedge clk) begin
    if (rstn && memBus.write) begin
      checkOutput("writePulse", 32'(prevWrite), 32'd0);
      checkOutput("writePending", 32'(expWrites.size() != 0), 32'd1);
      if (expWrites.size() != 0) begin
        WrExp w;
        w = expWrites.pop_front();
        checkOutput("writeAddr", 32'(memBus.addr), 32'(w.a));
        checkOutput("writeData", memBus.data, w.d);
      end
    end
    prevWrite <= memBus.write;
  end

  // Reply monitor: decodes each byte on tx and compares it with the oldest queued reply
  initial begin : txMonitor
    logic [7:0] got;
    logic [7:0] want;
    logic       stopBit;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          got[k] = tx;
        end
        repeat (DIV) @(negedge clk);
        stopBit = tx;
        checkOutput("replyStop", 32'(stopBit), 32'd1);
        checkOutput("replyPending", 32'(expReplies.size() != 0), 32'd1);
        if (expReplies.size() != 0) begin
          want = expReplies.pop_front();
          checkOutput("replyByte", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn   = 1'b0;
    enable = 1'b0;
    rx     = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rstTx", 32'(tx), 32'd1);
    checkOutput("rstWrite", 32'(memBus.write), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstAddr", 32'(memBus.addr), 32'd0);
    checkOutput("rstData", memBus.data, 32'd0);
    checkOutput("rstXorc", 32'(xorc), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);

    rstn = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] two-word frame with correct checksum");
    frameWords = {32'h12345678, 32'hDEADBEEF};
    applyStimulus(1'b0, 8'h00);
    waitIdle();
    checkOutput("aXorc", 32'(xorc), 32'(expXorc));
    checkOutput("aAddr", 32'(memBus.addr), 32'(expAddr));
    checkOutput("aErr", 32'(err), 32'(expErr));

    $display("[TB] same frame with checksum 0x00");
    rewindEnable();
    applyStimulus(1'b1, 8'h00);
    waitIdle();
    checkOutput("nakXorc", 32'(xorc), 32'(expXorc));
    checkOutput("nakAddr", 32'(memBus.addr), 32'(expAddr));

    $display("[TB] chained one-word frame");
    rewindEnable();
    applyStimulus(1'b0, 8'h00);
    waitIdle();
    frameWords = {32'h00000001};
    applyStimulus(1'b0, 8'h00);
    waitIdle();
    checkOutput("chainAddr", 32'(memBus.addr), 32'd3);
    checkOutput("chainXorc", 32'(xorc), 32'(expXorc));

    $display("[TB] framing error on LEN_L");
    rewindEnable();
    sendByte(TB_SYNC, 1'b1);
    sendByte(8'h02, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("frmErr", 32'(err), 32'b001);
    checkOutput("frmBusy", 32'(busy), 32'd0);
    repeat (1700) @(negedge clk);
    checkOutput("frmErrHeld", 32'(err), 32'b001);
    checkOutput("frmAddr", 32'(memBus.addr), 32'd0);

    $display("[TB] mid-payload stall");
    rewindEnable();
    sendByte(TB_SYNC, 1'b1);
    sendByte(8'h01, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h78, 1'b1);
    sendByte(8'h56, 1'b1);
    expXorc ^= 8'h78 ^ 8'h56;
    repeat (1000) @(negedge clk);
    checkOutput("toBusyBefore", 32'(busy), 32'd1);
    checkOutput("toErrBefore", 32'(err), 32'(expErr));
    repeat (800) @(negedge clk);
    expErr[1] = 1'b1;
    checkOutput("toErr", 32'(err), 32'(expErr));
    checkOutput("toBusy", 32'(busy), 32'd0);
    checkOutput("toXorc", 32'(xorc), 32'(expXorc));
    checkOutput("toAddr", 32'(memBus.addr), 32'd0);

    $display("[TB] address wrap");
    rewindEnable();
    frameWords = {};
    for (int i = 0; i < (1 << ADDR_W) - 1; i++) frameWords.push_back($urandom);
    applyStimulus(1'b0, 8'h00);
    waitIdle();
    checkOutput("preWrapAddr", 32'(memBus.addr), 32'((1 << ADDR_W) - 1));
    checkOutput("preWrapErr", 32'(err), 32'd0);
    frameWords = {$urandom, $urandom};
    applyStimulus(1'b0, 8'h00);
    waitIdle();
    checkOutput("wrapErr", 32'(err), 32'(expErr));
    checkOutput("wrapAddr", 32'(memBus.addr), 32'd1);

    $display("[TB] reset mid-frame");
    sendByte(TB_SYNC, 1'b1);
    sendByte(8'h03, 1'b1);
    @(negedge clk);
    checkOutput("midBusy", 32'(busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstAddr", 32'(memBus.addr), 32'd0);
    checkOutput("midRstErr", 32'(err), 32'd0);
    checkOutput("midRstXorc", 32'(xorc), 32'd0);
    checkOutput("midRstTx", 32'(tx), 32'd1);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    checkOutput("leftoverWrites", 32'(expWrites.size()), 32'd0);
    checkOutput("leftoverReplies", 32'(expReplies.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
